fpga_iser8_align: RTL

Word-alignment controller for the GoWin 8:1 input deserializer (`fpga_iser8`), running in the parallel-clock domain. It hunts for a fixed training word on the deserialized `q[7:0]` bus by issuing single-cycle CALIB (bitslip) pulses, then declares lock. One instance sits beside each deserialized lane in the PHY receive path. Link logic may only consume lane data while `locked` is high.

---
 rtl/fpga_iser8_align_pkg.sv | 45 ++++
 rtl/fpga_iser8_align.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fpga_iser8_align_pkg.sv
// Shared types and constants for the fpga_iser8 word-alignment controller.
package fpga_iser8_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } align_state_t;

  localparam logic [7:0]  ALIGN_PAT_DEF    = 8'hF0;
  localparam int unsigned ALIGN_SETTLE_DEF = 4;
  localparam int unsigned ALIGN_MATCH_DEF  = 16;
  localparam int unsigned ALIGN_LOSS_DEF   = 4;

  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned MATCH_W  = 8;
  localparam int unsigned LOSS_W   = 4;
  localparam int unsigned SLIP_W   = 3;

  // Last legal slip count; a mismatch here ends the attempt instead of slipping.
  localparam logic [SLIP_W-1:0] SLIP_LAST = 3'd7;

  // A training word is only usable if each of its 8 rotations is unique,
  // otherwise two bit offsets would look aligned.
  function automatic logic rotations_distinct(input logic [7:0] pat);
    logic [7:0] ri;
    logic [7:0] rj;
    logic       ok;
    ok = 1'b1;
    ri = pat;
    for (int i = 0; i < 8; i++) begin
      rj = {ri[6:0], ri[7]};
      for (int j = i + 1; j < 8; j++) begin
        if (rj == ri) ok = 1'b0;
        rj = {rj[6:0], rj[7]};
      end
      ri = {ri[6:0], ri[7]};
    end
    return ok;
  endfunction

endpackage

// File: rtl/fpga_iser8_align.sv
// Word-alignment controller for one fpga_iser8 lane (parallel-clock domain).
// Issues single-cycle CALIB (bitslip) pulses until TRAIN_PAT is seen
// MATCH_CNT times in a row, then holds locked.
// Optional feature macro: FPGA_ISER8_ALIGN_MONITOR_EN -- keeps checking the
// training word while locked and restarts alignment after LOSS_CNT
// consecutive mismatches. Without it LOCKED is sticky.
module fpga_iser8_align
  import fpga_iser8_align_pkg::*;
#(
  parameter logic [7:0]  TRAIN_PAT  = ALIGN_PAT_DEF,
  parameter int unsigned SETTLE_CYC = ALIGN_SETTLE_DEF,
  parameter int unsigned MATCH_CNT  = ALIGN_MATCH_DEF,
  parameter int unsigned LOSS_CNT   = ALIGN_LOSS_DEF
) (
  input  logic       clk_par,
  input  logic       srst,
  input  logic       start,
  input  logic [7:0] q,
  output logic       calib,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic [2:0] slip_cnt
);

  // Reject configurations the counters or the pattern cannot support.
  if (SETTLE_CYC < 1 || SETTLE_CYC > 15 || MATCH_CNT < 1 || MATCH_CNT > 255 ||
      LOSS_CNT < 1 || LOSS_CNT > 15 || !rotations_distinct(TRAIN_PAT)) begin : g_bad_param
    $error("fpga_iser8_align: illegal parameter set");
  end

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [MATCH_W-1:0]  MATCH_TOP   = MATCH_W'(MATCH_CNT);

  align_state_t        state;
  align_state_t        state_nxt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SETTLE_W-1:0] settle_nxt;
  logic [MATCH_W-1:0]  match_cnt;
  logic [MATCH_W-1:0]  match_nxt;
  logic [SLIP_W-1:0]   slip_nxt;
  logic                word_ok;
  logic                calib_nxt;
  logic                busy_nxt;
  logic                locked_nxt;
  logic                fail_nxt;

`ifdef FPGA_ISER8_ALIGN_MONITOR_EN
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_CNT - 1);
  logic [LOSS_W-1:0] loss_cnt;
  logic [LOSS_W-1:0] loss_nxt;
`endif

  // Match counter never counts past the lock threshold.
  function automatic logic [MATCH_W-1:0] match_sat_inc(input logic [MATCH_W-1:0] c);
    return (c == MATCH_TOP) ? c : c + 1'b1;
  endfunction

  assign word_ok = (q == TRAIN_PAT);

  // State and counter register.
  always_ff @(posedge clk_par) begin
    if (srst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      match_cnt  <= '0;
      slip_cnt   <= '0;
`ifdef FPGA_ISER8_ALIGN_MONITOR_EN
      loss_cnt   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      match_cnt  <= match_nxt;
      slip_cnt   <= slip_nxt;
`ifdef FPGA_ISER8_ALIGN_MONITOR_EN
      loss_cnt   <= loss_nxt;
`endif
    end
  end

  // Next-state and counter update; start overrides every other transition.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    match_nxt  = match_cnt;
    slip_nxt   = slip_cnt;
`ifdef FPGA_ISER8_ALIGN_MONITOR_EN
    loss_nxt   = loss_cnt;
`endif
    if (start) begin
      state_nxt  = ST_SETTLE;
      settle_nxt = '0;
      match_nxt  = '0;
      slip_nxt   = '0;
`ifdef FPGA_ISER8_ALIGN_MONITOR_EN
      loss_nxt   = '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: ;
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state_nxt  = ST_CHECK;
            settle_nxt = '0;
            match_nxt  = '0;
          end else begin
            settle_nxt = settle_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (word_ok) begin
            match_nxt = match_sat_inc(match_cnt);
            if (match_nxt == MATCH_TOP) state_nxt = ST_LOCKED;
          end else if (slip_cnt == SLIP_LAST) begin
            state_nxt = ST_FAIL;
          end else begin
            state_nxt = ST_SLIP;
          end
        end
        ST_SLIP: begin
          state_nxt = ST_SETTLE;
          slip_nxt  = slip_cnt + 1'b1;
        end
        ST_LOCKED: begin
`ifdef FPGA_ISER8_ALIGN_MONITOR_EN
          if (word_ok) begin
            loss_nxt = '0;
          end else if (loss_cnt == LOSS_LAST) begin
            state_nxt  = ST_SETTLE;
            settle_nxt = '0;
            match_nxt  = '0;
            slip_nxt   = '0;
            loss_nxt   = '0;
          end else begin
            loss_nxt = loss_cnt + 1'b1;
          end
`endif
        end
        ST_FAIL: ;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so flags line up with it; calib
  // follows the SLIP cycle and is dropped if start aborts the slip.
  always_comb begin
    calib_nxt  = (state == ST_SLIP) && !start;
    busy_nxt   = (state_nxt == ST_SETTLE) || (state_nxt == ST_CHECK) ||
                 (state_nxt == ST_SLIP);
    locked_nxt = (state_nxt == ST_LOCKED);
    fail_nxt   = (state_nxt == ST_FAIL);
  end

  // Registered outputs.
  always_ff @(posedge clk_par) begin
    if (srst) begin
      calib  <= 1'b0;
      busy   <= 1'b0;
      locked <= 1'b0;
      fail   <= 1'b0;
    end else begin
      calib  <= calib_nxt;
      busy   <= busy_nxt;
      locked <= locked_nxt;
      fail   <= fail_nxt;
    end
  end

endmodule
